// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand-entry datapath:
// key codes, entry FSM states and operand sizing.
package calc_pkg;

  localparam int OPERAND_WIDTH = 10;
  localparam int MAX_DIGITS    = 3;

  localparam logic [3:0] KEY_CLEAR = 4'd10;
  localparam logic [3:0] KEY_BSP   = 4'd11;
  localparam logic [3:0] KEY_ENTER = 4'd12;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ENTRY = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic logic is_digit_key(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_stack_to_bin.sv
// Combinational BCD-to-binary conversion of the lowest `count` stack entries.
// Entry 0 holds the most significant (first entered) digit.
module bcd_stack_to_bin #(
  parameter int MAX_DIGITS = 3,
  parameter int WIDTH      = 10
) (
  input  logic [4*MAX_DIGITS-1:0] digits,
  input  logic [1:0]              count,
  output logic [WIDTH-1:0]        value
);
  import calc_pkg::*;

  logic [WIDTH-1:0] acc;

  // Horner evaluation with shift-add multiply by ten; no divider needed.
  always_comb begin
    acc = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < int'(count)) begin
        acc = (acc << 3) + (acc << 1) + {{(WIDTH-4){1'b0}}, digits[4*i +: 4]};
      end
    end
  end

  assign value = acc;

endmodule

// File: rtl/operand_digit_entry.sv
// Keypad operand entry: accumulates up to MAX_DIGITS decimal keys into a binary
// operand, supports clear/backspace, and hands the result off with valid/ready.
module operand_digit_entry #(
  parameter int MAX_DIGITS = calc_pkg::MAX_DIGITS,
  parameter int WIDTH      = calc_pkg::OPERAND_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             KEY_VALID,
  input  logic [3:0]       KEY_CODE,
  output logic             KEY_READY,
  output logic [WIDTH-1:0] OUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [1:0]       DIGIT_COUNT,
  output logic             ERR
);
  import calc_pkg::*;

  // Handshakes: a key transfers on a rising edge with KEY_VALID & KEY_READY;
  // the operand transfers on a rising edge with OUT_VALID & OUT_READY, and
  // OUT/OUT_VALID are held stable until that edge.

  state_t                  state_q, state_d;
  logic [4*MAX_DIGITS-1:0] stack_q, stack_d;
  logic [1:0]              count_q, count_d;
  logic [WIDTH-1:0]        out_q, out_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;

  logic                    key_fire;
  logic                    digit_key;
  logic                    at_max;
  logic                    leading_zero;
  logic [1:0]              count_dec;
  logic [WIDTH-1:0]        appended;
  logic [WIDTH-1:0]        pop_value;

  assign key_fire     = KEY_VALID && (state_q != HOLD);
  assign digit_key    = is_digit_key(KEY_CODE);
  assign at_max       = (count_q == 2'(MAX_DIGITS));
  assign leading_zero = (KEY_CODE == 4'd0) && (count_q == 2'd0);
  assign count_dec    = count_q - 2'd1;
  assign appended     = (out_q << 3) + (out_q << 1) + {{(WIDTH-4){1'b0}}, KEY_CODE};

  // Value of the stack with its top digit removed, for backspace.
  bcd_stack_to_bin #(
    .MAX_DIGITS(MAX_DIGITS),
    .WIDTH     (WIDTH)
  ) u_pop_value (
    .digits(stack_q),
    .count (count_dec),
    .value (pop_value)
  );

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD: begin
        if (OUT_READY) state_d = EMPTY;
      end
      default: begin
        if (key_fire) begin
          if (digit_key) begin
            if (!at_max && !leading_zero) state_d = ENTRY;
          end else begin
            case (KEY_CODE)
              KEY_CLEAR: state_d = EMPTY;
              KEY_BSP:   if (count_q == 2'd1) state_d = EMPTY;
              KEY_ENTER: state_d = HOLD;
              default:   state_d = state_q;
            endcase
          end
        end
      end
    endcase
  end

  // Output / datapath next values
  always_comb begin
    stack_d = stack_q;
    count_d = count_q;
    out_d   = out_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    case (state_q)
      HOLD: begin
        if (OUT_READY) begin
          stack_d = '0;
          count_d = 2'd0;
          out_d   = '0;
          valid_d = 1'b0;
        end
      end
      default: begin
        if (key_fire) begin
          if (digit_key) begin
            if (at_max) begin
              err_d = 1'b1;
            end else if (!leading_zero) begin
              stack_d[4*count_q +: 4] = KEY_CODE;
              count_d                 = count_q + 2'd1;
              out_d                   = appended;
            end
          end else begin
            case (KEY_CODE)
              KEY_CLEAR: begin
                stack_d = '0;
                count_d = 2'd0;
                out_d   = '0;
              end
              KEY_BSP: begin
                if (count_q != 2'd0) begin
                  stack_d[4*count_dec +: 4] = 4'd0;
                  count_d                   = count_dec;
                  out_d                     = pop_value;
                end
              end
              KEY_ENTER: valid_d = 1'b1;
              default:   err_d   = 1'b1;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stack_q <= '0;
      count_q <= 2'd0;
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      stack_q <= stack_d;
      count_q <= count_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign KEY_READY   = (state_q != HOLD);
  assign OUT         = out_q;
  assign OUT_VALID   = valid_q;
  assign DIGIT_COUNT = count_q;
  assign ERR         = err_q;

endmodule
